mo_linebuf_sched: RTL and testbench
===================================

# mo_linebuf_sched

Scheduler for the motion-object horizontal line buffers. It owns the A/B ping-pong select (PADB) and swaps buffers at each line start. It sequences the display-side read-and-clear scan of one buffer and arbitrates motion-object pixel writes into the other. It sits between the motion-object pixel pipeline (MOSR/PP datapath) and the two line-buffer RAMs, replacing the discrete PADB flip-flop and chip-select gating.

## Interface
Parameters:
- HPIX, 336, visible pixels per line; scan length.
- XW, 9, line-buffer address width; HPIX ≤ 2^XW.
- MAXW, 256, maximum accepted pixel writes per line.

Ports:
- MCKR  in  1  system clock; all state changes on its rising edge.
- RESET_b  in  1  synchronous, active-low reset.
- LINE_START  in  1  one-cycle pulse at start of horizontal blank.
- BUFCLR_b  in  1  low = suppress clearing during scan (buffers retain data).
- PIX_VALID  in  1  pixel write request from MO pipeline.
- PIX_X  in  XW  target x position.
- PIX_DATA  in  8  {palette[3:0], MOSR[3:0]}; MOSR[3:0]==4'hF is transparent.
- PIX_READY  out  1  write accepted when PIX_VALID & PIX_READY at clock edge.
- PADB  out  1  0: A is the write (render) buffer and B is scanned; 1: the reverse.
- WR_ADDR  out  XW  render-side address.
- WR_DATA  out  8  render-side data.
- WR_EN_A, WR_EN_B  out  1  render write strobes, active high.
- RD_ADDR  out  XW  scan address.
- RD_VALID  out  1  RD_ADDR valid this cycle.
- CLR_EN_A, CLR_EN_B  out  1  clear-to-zero strobes for the scanned buffer.
- SCAN_ABORT  out  1  one-cycle pulse: LINE_START arrived before scan completed.
- DROP_CNT  out  8  saturating count of writes refused due to MAXW this line.

## Operation
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE→SCAN on LINE_START.
  - SCAN→DONE after address HPIX-1.
  - DONE→SCAN on the next LINE_START.
- On every LINE_START: PADB toggles; RD_ADDR restarts at 0; write count and DROP_CNT clear.
- SCAN: RD_ADDR increments by 1 per cycle and RD_VALID=1.
  - CLR_EN_x is asserted for the scanned buffer (B when PADB=0) when BUFCLR_b=1.
  - The RAM reads before it writes, so the read and clear of an address happen in the same cycle.
- Render side:
  - PIX_READY = (write count < MAXW) and not in reset.
  - An accepted pixel with MOSR==4'hF or PIX_X ≥ HPIX produces no write but still counts as accepted.
  - Otherwise WR_EN of the render buffer pulses with the registered address and data.
  - The write count increments on every accepted pixel.
  - While PIX_READY=0, each PIX_VALID cycle increments DROP_CNT, saturating at 255.
- Simultaneous LINE_START and an accepted pixel: the pixel is written to the pre-toggle buffer and is counted against the old line. The new line's count starts at 0.
- LINE_START while in SCAN: SCAN_ABORT pulses, the scan restarts at 0 on the new buffer, and the unscanned tail of the old buffer is not cleared.
- WR_EN_A/B and CLR_EN_A/B never target the same buffer in the same cycle.

## Timing
- Reset values: PADB=0, state IDLE, all enables 0, RD_VALID=0, RD_ADDR=0, WR_ADDR=0, WR_DATA=0, DROP_CNT=0, PIX_READY=0, SCAN_ABORT=0.
- PIX_READY rises the first cycle after RESET_b=1.
- LINE_START sampled at edge n gives PADB toggled, RD_ADDR=0 and RD_VALID=1 from edge n+1. The last scan address is at n+HPIX; RD_VALID=0 from n+HPIX+1.
- Write latency is 1: a pixel accepted at edge n gives WR_EN/WR_ADDR/WR_DATA valid from n+1 for one cycle. Throughput is one pixel per cycle.
- Reset mid-scan or mid-write takes effect at the next edge with no residual strobes.

## Structure
- Shared graphics package holds:
  - typedef `lb_sel_t` (enum BUF_A=0, BUF_B=1);
  - scan FSM enum `lb_scan_state_t`;
  - constant `MO_TRANSPARENT = 4'hF`.
- One natural sub-module: `lb_scan_counter` (IDLE/SCAN/DONE FSM, RD_ADDR counter, abort detection). Write arbitration and PADB stay in the top level.

## Test plan
- Reset, then LINE_START → PADB=1 from next edge; RD_ADDR 0..335 with CLR_EN_A=1; RD_VALID=0 at cycle 337.
- PADB=0, pixel X=10 with DATA=8'h53 → one cycle later WR_EN_A=1, WR_ADDR=10, WR_DATA=8'h53, WR_EN_B=0.
- Pixel with DATA=8'h2F, then pixel with X=400 → both accepted, no WR_EN asserted, write count=2.
- 260 back-to-back valid pixels → PIX_READY falls after 256 accepts, DROP_CNT=4; next LINE_START restores PIX_READY=1 and DROP_CNT=0.
- LINE_START again at scan address 100 → SCAN_ABORT pulses, PADB toggles, RD_ADDR=0, and clears now target the other buffer.
- BUFCLR_b=0 during a full scan → RD_VALID runs 336 cycles with CLR_EN_A=CLR_EN_B=0 throughout.

Source files
------------

// File: rtl/mo_linebuf_sched_pkg.sv
// Shared motion-object graphics types: line-buffer select, scan FSM states,
// and the transparent-pixel code.
package mo_linebuf_sched_pkg;

  typedef enum logic {
    BUF_A = 1'b0,
    BUF_B = 1'b1
  } lb_sel_t;

  typedef enum logic [1:0] {
    LB_IDLE = 2'd0,
    LB_SCAN = 2'd1,
    LB_DONE = 2'd2
  } lb_scan_state_t;

  localparam logic [3:0] MO_TRANSPARENT = 4'hF;

  function automatic lb_sel_t lb_other(input lb_sel_t sel);
    return (sel == BUF_A) ? BUF_B : BUF_A;
  endfunction

endpackage

// File: rtl/mo_linebuf_sched_scan_counter.sv
// Display-side scan sequencer: IDLE/SCAN/DONE FSM, read address counter,
// and detection of a line start that cuts a scan short.
module lb_scan_counter
  import mo_linebuf_sched_pkg::*;
#(
  parameter int unsigned HPIX = 336,
  parameter int unsigned XW   = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_start,
  output logic [XW-1:0] rd_addr,
  output logic          rd_valid,
  output logic          scan_abort
);

  localparam logic [XW-1:0] LAST_ADDR = XW'(HPIX - 1);

  lb_scan_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= LB_IDLE;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
      scan_abort <= 1'b0;
    end else begin
      scan_abort <= 1'b0;
      if (line_start) begin
        // A line start on the final address lets that scan complete normally.
        scan_abort <= (state == LB_SCAN) && (rd_addr != LAST_ADDR);
        state      <= LB_SCAN;
        rd_addr    <= '0;
        rd_valid   <= 1'b1;
      end else begin
        case (state)
          LB_SCAN: begin
            if (rd_addr == LAST_ADDR) begin
              state    <= LB_DONE;
              rd_addr  <= '0;
              rd_valid <= 1'b0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
          default: begin
            rd_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mo_linebuf_sched.sv
// Motion-object line-buffer scheduler: owns the A/B ping-pong select, gates
// pixel writes into the render buffer and clears into the scanned buffer.
module mo_linebuf_sched
  import mo_linebuf_sched_pkg::*;
#(
  parameter int unsigned HPIX = 336,
  parameter int unsigned XW   = 9,
  parameter int unsigned MAXW = 256
) (
  input  logic          MCKR,
  input  logic          RESET_b,
  input  logic          LINE_START,
  input  logic          BUFCLR_b,
  input  logic          PIX_VALID,
  input  logic [XW-1:0] PIX_X,
  input  logic [7:0]    PIX_DATA,
  output logic          PIX_READY,
  output logic          PADB,
  output logic [XW-1:0] WR_ADDR,
  output logic [7:0]    WR_DATA,
  output logic          WR_EN_A,
  output logic          WR_EN_B,
  output logic [XW-1:0] RD_ADDR,
  output logic          RD_VALID,
  output logic          CLR_EN_A,
  output logic          CLR_EN_B,
  output logic          SCAN_ABORT,
  output logic [7:0]    DROP_CNT
);

  localparam int unsigned CW = $clog2(MAXW + 1);

  lb_sel_t       padb_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] wr_cnt_nxt;
  logic          accept;
  logic          refuse;
  logic          pix_write;
  logic          clr_ok;

  lb_scan_counter #(
    .HPIX (HPIX),
    .XW   (XW)
  ) u_scan (
    .clk        (MCKR),
    .rst_n      (RESET_b),
    .line_start (LINE_START),
    .rd_addr    (RD_ADDR),
    .rd_valid   (RD_VALID),
    .scan_abort (SCAN_ABORT)
  );

  always_comb begin
    accept     = PIX_VALID & PIX_READY;
    refuse     = PIX_VALID & ~PIX_READY;
    pix_write  = accept && (PIX_DATA[3:0] != MO_TRANSPARENT) && (32'(PIX_X) < HPIX);
    // The accepting cycle still belongs to the old line, so a coincident
    // line start simply zeroes the count after it.
    wr_cnt_nxt = LINE_START ? '0 : wr_cnt + {{(CW-1){1'b0}}, accept};
  end

  always_ff @(posedge MCKR) begin
    if (!RESET_b) begin
      padb_q    <= BUF_A;
      wr_cnt    <= '0;
      PIX_READY <= 1'b0;
      DROP_CNT  <= '0;
      WR_EN_A   <= 1'b0;
      WR_EN_B   <= 1'b0;
      WR_ADDR   <= '0;
      WR_DATA   <= '0;
    end else begin
      wr_cnt    <= wr_cnt_nxt;
      PIX_READY <= (32'(wr_cnt_nxt) < MAXW);
      WR_EN_A   <= pix_write && (padb_q == BUF_A);
      WR_EN_B   <= pix_write && (padb_q == BUF_B);
      if (pix_write) begin
        WR_ADDR <= PIX_X;
        WR_DATA <= PIX_DATA;
      end
      if (LINE_START) begin
        padb_q   <= lb_other(padb_q);
        DROP_CNT <= '0;
      end else if (refuse && (DROP_CNT != 8'hFF)) begin
        DROP_CNT <= DROP_CNT + 8'd1;
      end
    end
  end

  // A late write landing in the freshly scanned buffer wins over its clear,
  // keeping the two strobes of one buffer mutually exclusive.
  always_comb begin
    PADB     = (padb_q == BUF_B);
    clr_ok   = RD_VALID & BUFCLR_b;
    CLR_EN_A = clr_ok & (padb_q == BUF_B) & ~WR_EN_A;
    CLR_EN_B = clr_ok & (padb_q == BUF_A) & ~WR_EN_B;
  end

endmodule

// File: tb/tb_mo_linebuf_sched.sv
// Self-checking bench for mo_linebuf_sched: directed line/pixel scenarios
// followed by randomized traffic against a per-line behavioural model.
module tb_mo_linebuf_sched;

  localparam int HPIX = 336;
  localparam int XW   = 9;
  localparam int MAXW = 256;

  logic          MCKR = 1'b0;
  logic          RESET_b;
  logic          LINE_START;
  logic          BUFCLR_b;
  logic          PIX_VALID;
  logic [XW-1:0] PIX_X;
  logic [7:0]    PIX_DATA;
  logic          PIX_READY;
  logic          PADB;
  logic [XW-1:0] WR_ADDR;
  logic [7:0]    WR_DATA;
  logic          WR_EN_A;
  logic          WR_EN_B;
  logic [XW-1:0] RD_ADDR;
  logic          RD_VALID;
  logic          CLR_EN_A;
  logic          CLR_EN_B;
  logic          SCAN_ABORT;
  logic [7:0]    DROP_CNT;

  mo_linebuf_sched #(
    .HPIX (HPIX),
    .XW   (XW),
    .MAXW (MAXW)
  ) dut (
    .MCKR       (MCKR),
    .RESET_b    (RESET_b),
    .LINE_START (LINE_START),
    .BUFCLR_b   (BUFCLR_b),
    .PIX_VALID  (PIX_VALID),
    .PIX_X      (PIX_X),
    .PIX_DATA   (PIX_DATA),
    .PIX_READY  (PIX_READY),
    .PADB       (PADB),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .WR_EN_A    (WR_EN_A),
    .WR_EN_B    (WR_EN_B),
    .RD_ADDR    (RD_ADDR),
    .RD_VALID   (RD_VALID),
    .CLR_EN_A   (CLR_EN_A),
    .CLR_EN_B   (CLR_EN_B),
    .SCAN_ABORT (SCAN_ABORT),
    .DROP_CNT   (DROP_CNT)
  );

  always #5 MCKR = ~MCKR;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: line-level state (buffer owner, cycles since line
  // start, accepted/refused counts) plus the pending render write.
  int m_padb  = 0;
  int m_pos   = -1;
  int m_cnt   = 0;
  int m_drop  = 0;
  int m_ready = 0;
  int m_wa    = 0;
  int m_wd    = 0;
  int m_wea   = 0;
  int m_web   = 0;
  int m_abort = 0;
  bit model_on = 1'b0;

  always @(posedge MCKR) begin : model
    int acc;
    int drp;
    if (!RESET_b) begin
      m_padb = 0; m_pos = -1; m_cnt = 0; m_drop = 0; m_ready = 0;
      m_wa = 0; m_wd = 0; m_wea = 0; m_web = 0; m_abort = 0;
    end else begin
      acc = (PIX_VALID && m_ready != 0) ? 1 : 0;
      drp = (PIX_VALID && m_ready == 0) ? 1 : 0;
      m_wea = 0;
      m_web = 0;
      if (acc == 1 && PIX_DATA[3:0] != 4'hF && int'(PIX_X) < HPIX) begin
        if (m_padb == 0) m_wea = 1; else m_web = 1;
        m_wa = int'(PIX_X);
        m_wd = int'(PIX_DATA);
      end
      m_cnt += acc;
      if (LINE_START) begin
        m_abort = (m_pos >= 0 && m_pos < HPIX - 1) ? 1 : 0;
        m_padb  = 1 - m_padb;
        m_pos   = 0;
        m_cnt   = 0;
        m_drop  = 0;
      end else begin
        m_abort = 0;
        if (m_pos >= 0) begin
          m_pos++;
          if (m_pos == HPIX) m_pos = -1;
        end
        if (drp == 1 && m_drop < 255) m_drop++;
      end
      m_ready = (m_cnt < MAXW) ? 1 : 0;
    end
    model_on = 1'b1;
  end

  always @(negedge MCKR) begin : compare
    int rv;
    int ra;
    int ce_a;
    int ce_b;
    if (model_on) begin
      rv   = (m_pos >= 0) ? 1 : 0;
      ra   = (m_pos >= 0) ? m_pos : 0;
      ce_a = (rv == 1 && BUFCLR_b && m_padb == 1 && m_wea == 0) ? 1 : 0;
      ce_b = (rv == 1 && BUFCLR_b && m_padb == 0 && m_web == 0) ? 1 : 0;
      check("padb",       PADB,       m_padb);
      check("pix_ready",  PIX_READY,  m_ready);
      check("rd_valid",   RD_VALID,   rv);
      check("rd_addr",    RD_ADDR,    ra);
      check("scan_abort", SCAN_ABORT, m_abort);
      check("drop_cnt",   DROP_CNT,   m_drop);
      check("wr_en_a",    WR_EN_A,    m_wea);
      check("wr_en_b",    WR_EN_B,    m_web);
      check("wr_addr",    WR_ADDR,    m_wa);
      check("wr_data",    WR_DATA,    m_wd);
      check("clr_en_a",   CLR_EN_A,   ce_a);
      check("clr_en_b",   CLR_EN_B,   ce_b);
      check("wr_clr_excl", (WR_EN_A & CLR_EN_A) | (WR_EN_B & CLR_EN_B), 0);
    end
  end

  task automatic tick();
    @(posedge MCKR);
    #1;
  endtask

  task automatic pulse_ls();
    LINE_START = 1'b1;
    tick();
    LINE_START = 1'b0;
  endtask

  task automatic send_pix(input int x, input int d);
    PIX_VALID = 1'b1;
    PIX_X     = XW'(x);
    PIX_DATA  = 8'(d);
    tick();
    PIX_VALID = 1'b0;
  endtask

  initial begin : stim
    int rv_n;
    int clr_n;
    RESET_b    = 1'b0;
    LINE_START = 1'b0;
    BUFCLR_b   = 1'b1;
    PIX_VALID  = 1'b0;
    PIX_X      = '0;
    PIX_DATA   = '0;
    repeat (3) tick();
    check("rst_padb",     PADB,      0);
    check("rst_ready",    PIX_READY, 0);
    check("rst_rd_valid", RD_VALID,  0);
    check("rst_drop",     DROP_CNT,  0);

    RESET_b = 1'b1;
    tick();
    check("ready_after_rst", PIX_READY, 1);

    // First line: scan of A after the toggle.
    pulse_ls();
    check("ls1_padb",  PADB,     1);
    check("ls1_addr",  RD_ADDR,  0);
    check("ls1_valid", RD_VALID, 1);
    check("ls1_clr_a", CLR_EN_A, 1);
    repeat (335) tick();
    check("ls1_last_addr",  RD_ADDR,  335);
    check("ls1_last_valid", RD_VALID, 1);
    tick();
    check("ls1_scan_end", RD_VALID, 0);

    // Render into A.
    pulse_ls();
    check("ls2_padb", PADB, 0);
    send_pix(10, 8'h53);
    check("pix_wr_en_a", WR_EN_A, 1);
    check("pix_wr_addr", WR_ADDR, 10);
    check("pix_wr_data", WR_DATA, 8'h53);
    check("pix_wr_en_b", WR_EN_B, 0);

    // Transparent and off-screen pixels are accepted but not written.
    pulse_ls();
    send_pix(20, 8'h2F);
    check("transp_no_wr", WR_EN_A | WR_EN_B, 0);
    send_pix(400, 8'h12);
    check("offscr_no_wr", WR_EN_A | WR_EN_B, 0);
    check("model_wcnt", m_cnt, 2);

    // MAXW limit and drop counting.
    pulse_ls();
    PIX_VALID = 1'b1;
    for (int i = 0; i < 260; i++) begin
      PIX_X    = XW'($urandom_range(0, HPIX - 1));
      PIX_DATA = 8'($urandom);
      tick();
    end
    PIX_VALID = 1'b0;
    check("maxw_ready", PIX_READY, 0);
    check("maxw_drop",  DROP_CNT,  4);
    pulse_ls();
    check("newline_ready", PIX_READY, 1);
    check("newline_drop",  DROP_CNT,  0);

    // Abort mid-scan at address 100.
    for (int i = 0; i < 400 && RD_ADDR != XW'(100); i++) tick();
    check("abort_sync",    RD_ADDR,  100);
    check("pre_abort_clr", CLR_EN_A, 1);
    pulse_ls();
    check("abort_pulse", SCAN_ABORT, 1);
    check("abort_padb",  PADB,       0);
    check("abort_addr",  RD_ADDR,    0);
    check("abort_clr_b", CLR_EN_B,   1);
    check("abort_clr_a", CLR_EN_A,   0);
    tick();
    check("abort_one_cycle", SCAN_ABORT, 0);
    repeat (340) tick();

    // Clearing suppressed for a full scan.
    BUFCLR_b = 1'b0;
    pulse_ls();
    rv_n  = 0;
    clr_n = 0;
    for (int i = 0; i < 340; i++) begin
      rv_n  += int'(RD_VALID);
      clr_n += int'(CLR_EN_A | CLR_EN_B);
      tick();
    end
    check("noclr_scan_len", rv_n,  336);
    check("noclr_no_clear", clr_n, 0);
    BUFCLR_b = 1'b1;

    // Drop counter saturation.
    pulse_ls();
    PIX_VALID = 1'b1;
    repeat (MAXW + 300) tick();
    PIX_VALID = 1'b0;
    check("drop_saturate", DROP_CNT, 255);

    // Reset mid-scan with a write in flight.
    pulse_ls();
    repeat (50) tick();
    PIX_VALID = 1'b1;
    PIX_X     = XW'(5);
    PIX_DATA  = 8'h01;
    tick();
    RESET_b = 1'b0;
    tick();
    PIX_VALID = 1'b0;
    check("midrst_wr",    WR_EN_A | WR_EN_B,   0);
    check("midrst_clr",   CLR_EN_A | CLR_EN_B, 0);
    check("midrst_valid", RD_VALID,            0);
    check("midrst_padb",  PADB,                0);
    RESET_b = 1'b1;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      RESET_b    = ($urandom_range(0, 1999) != 0);
      LINE_START = ($urandom_range(0, 349) == 0);
      PIX_VALID  = ($urandom_range(0, 3) != 0);
      PIX_X      = XW'($urandom_range(0, 511));
      PIX_DATA   = 8'($urandom);
      if ($urandom_range(0, 199) == 0) BUFCLR_b = ~BUFCLR_b;
      tick();
    end
    RESET_b    = 1'b1;
    LINE_START = 1'b0;
    PIX_VALID  = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
